// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling UART receiver, 8 data bits, optional odd parity, 1 stop
//
// Purpose:
//    Receives one UART frame at a time from iRx and presents the byte with error flags.
//    Frame: start (0), 8 data bits LSB first, [odd parity], stop (1).
//    The line is synchronised by two flops; all decisions use the synchronised copy.
//    The start bit is confirmed at mid-bit, and the data, parity and stop bits are
//    then sampled one full bit period apart, which places each sample at mid-bit.
//
// Configuration macro:
//    UART_RX_PARITY_EN - when defined, a parity bit follows the data bits and is checked.
//                        When undefined, the frame is 8N1 and oParityErr is always 0.
//
// Ports:
//    iClk        in   1  clock, all logic on posedge
//    iRst        in   1  synchronous active-high reset
//    iRx         in   1  serial line, asynchronous, idles high
//    odata       out  8  last received byte, held until the next oValid
//    oValid      out  1  one-cycle pulse when odata and the error flags update
//    oParityErr  out  1  parity mismatch on the frame reported by oValid
//    oFrameErr   out  1  stop bit sampled low on the frame reported by oValid
//    oBusy       out  1  receiver is not idle

module uart_receiver #(
   parameter int CLKS_PER_BIT = 434,
   parameter int CNT_W        = 16
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iRx,
   output logic [7:0] odata,
   output logic       oValid,
   output logic       oParityErr,
   output logic       oFrameErr,
   output logic       oBusy
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   state_t           state_q, state_d;
   logic             rx_meta_q, rx_s_q;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             pe_q, pe_d;
   logic             fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
   logic             perr_q, perr_d;
`endif

   logic             at_last;
   assign at_last = (timer_q == LAST_CNT);

   always_comb begin
      state_d = state_q;
      timer_d = at_last ? '0 : timer_q + CNT_W'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      pe_d    = pe_q;
      fe_d    = fe_q;
`ifdef UART_RX_PARITY_EN
      perr_d  = perr_q;
`endif

      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (!rx_s_q) state_d = S_START;
         end
         S_START: begin
            // Confirm the start bit at its middle; a high here means the low was a glitch.
            if (timer_q == HALF_CNT) state_d = rx_s_q ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (at_last) begin
               shift_d[idx_q] = rx_s_q;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (at_last) begin
               // Data plus parity must hold an odd number of ones.
               perr_d  = ~(^shift_q ^ rx_s_q);
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            // Report at mid-stop and go idle so a back-to-back start edge is not missed.
            if (at_last) begin
               data_d  = shift_q;
               valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               pe_d    = perr_q;
`else
               pe_d    = 1'b0;
`endif
               fe_d    = ~rx_s_q;
               state_d = rx_s_q ? S_IDLE : S_BREAK;
            end
         end
         S_BREAK: begin
            timer_d = '0;
            if (rx_s_q) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d != state_q) timer_d = '0;
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q   <= S_IDLE;
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         timer_q   <= '0;
         idx_q     <= 3'd0;
         shift_q   <= 8'h00;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         pe_q      <= 1'b0;
         fe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         rx_meta_q <= iRx;
         rx_s_q    <= rx_meta_q;
         timer_q   <= timer_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         pe_q      <= pe_d;
         fe_q      <= fe_d;
`ifdef UART_RX_PARITY_EN
         perr_q    <= perr_d;
`endif
      end
   end

   assign odata      = data_q;
   assign oValid     = valid_q;
   assign oParityErr = pe_q;
   assign oFrameErr  = fe_q;
   assign oBusy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver

module tb_uart_receiver;

   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } rec_t;

   logic       clk;
   logic       iRst;
   logic       iRx;
   logic [7:0] odata;
   logic       oValid;
   logic       oParityErr;
   logic       oFrameErr;
   logic       oBusy;

   int   n_assert;
   int   n_fail;
   rec_t got[$];
   rec_t exp_q[$];

   uart_receiver #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
      .iClk       (clk),
      .iRst       (iRst),
      .iRx        (iRx),
      .odata      (odata),
      .oValid     (oValid),
      .oParityErr (oParityErr),
      .oFrameErr  (oFrameErr),
      .oBusy      (oBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every cycle with oValid high is one reported frame.
   always @(negedge clk) begin
      if (oValid === 1'b1) begin
         rec_t r;
         r.d  = odata;
         r.pe = oParityErr;
         r.fe = oFrameErr;
         got.push_back(r);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: a frame is a list of line levels, one per bit time; the expected report
   // follows directly from the byte, the parity bit sent and the stop level sent.
   task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
      logic bits[$];
      rec_t r;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
      if (PAR_EN) bits.push_back(par);
      bits.push_back(stp);
      foreach (bits[k]) begin
         iRx = bits[k];
         repeat (CPB) @(negedge clk);
      end
      r.d  = b;
      r.pe = PAR_EN && (par != ~^b);
      r.fe = ~stp;
      exp_q.push_back(r);
   endtask

   task automatic check_frames(input string tag);
      rec_t e;
      rec_t g;
      chk({tag, "_count"}, got.size(), exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got.size() > 0) begin
            g = got.pop_front();
            chk({tag, "_data"}, g.d, e.d);
            chk({tag, "_perr"}, g.pe, e.pe);
            chk({tag, "_ferr"}, g.fe, e.fe);
         end
      end
      got.delete();
   endtask

   initial begin
      logic [7:0] b;
      logic       p;
      n_assert = 0;
      n_fail   = 0;
      iRst     = 1'b1;
      iRx      = 1'b1;
      repeat (4) @(negedge clk);
      chk("reset_odata", odata, 8'h00);
      chk("reset_valid", oValid, 1'b0);
      chk("reset_perr", oParityErr, 1'b0);
      chk("reset_ferr", oFrameErr, 1'b0);
      chk("reset_busy", oBusy, 1'b0);
      iRst = 1'b0;
      repeat (CPB) @(negedge clk);

      // Good frame with correct parity.
      send_frame(8'hA5, 1'b1, 1'b1);
      check_frames("a5");
      chk("a5_busy_low", oBusy, 1'b0);
      repeat (CPB) @(negedge clk);

      // Wrong parity bit.
      send_frame(8'h01, 1'b1, 1'b1);
      check_frames("perr");
      repeat (CPB) @(negedge clk);

      // Stop bit low followed by a held break.
      send_frame(8'h3C, ~^8'h3C, 1'b0);
      repeat (40) @(negedge clk);
      check_frames("break");
      chk("break_busy_held", oBusy, 1'b1);
      iRx = 1'b1;
      repeat (6) @(negedge clk);
      chk("break_busy_released", oBusy, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      chk("break_no_second_valid", got.size(), 0);

      // Short low glitch is rejected at mid-start.
      iRx = 1'b0;
      repeat (4) @(negedge clk);
      chk("glitch_busy_seen", oBusy, 1'b1);
      iRx = 1'b1;
      repeat (10) @(negedge clk);
      chk("glitch_busy_dropped", oBusy, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      chk("glitch_no_valid", got.size(), 0);

      // Reset during data bit 3 of 0xFF, then a full 0x00 frame.
      iRx = 1'b0;
      repeat (CPB) @(negedge clk);
      iRx = 1'b1;
      repeat (3 * CPB + CPB / 2) @(negedge clk);
      iRst = 1'b1;
      @(negedge clk);
      iRst = 1'b0;
      chk("midreset_odata", odata, 8'h00);
      chk("midreset_busy", oBusy, 1'b0);
      repeat (8 * CPB) @(negedge clk);
      chk("midreset_no_valid", got.size(), 0);
      send_frame(8'h00, 1'b1, 1'b1);
      check_frames("after_reset");
      repeat (CPB) @(negedge clk);

      // Back-to-back frames with no idle between them.
      send_frame(8'h00, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      send_frame(8'h55, 1'b1, 1'b1);
      check_frames("b2b");
      repeat (CPB) @(negedge clk);

      // Random bytes, random parity bit, random idle gaps.
      for (int n = 0; n < 12; n++) begin
         b = 8'($urandom);
         p = 1'($urandom_range(0, 1));
         send_frame(b, p, 1'b1);
         repeat ($urandom_range(0, 20)) @(negedge clk);
         check_frames("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
